// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 exception/interrupt unit: arbitrates exceptions against
// synchronized hardware interrupts, holds SR/Cause/EPC/PRId and serves
// mfc0/mtc0/eret from the M stage.
module cp0_exception_unit #(
    parameter logic [31:0] PRID       = 32'h2022_0707,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    localparam logic [4:0] AddrSr    = 5'd12;
    localparam logic [4:0] AddrCause = 5'd13;
    localparam logic [4:0] AddrEpc   = 5'd14;
    localparam logic [4:0] AddrPrid  = 5'd15;

    logic [5:0]  hw_m_q, hw_s_q;
    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q;
    logic [4:0]  exc_q, exc_d;
    logic [31:2] epc_q, epc_d;
    logic        int_req, exc_req;
    logic [31:0] victim_pc;

    // Request arbitration; EXL blocks both sources, so no nesting.
    always_comb begin
        int_req = (|(hw_s_q & im_q)) & ie_q & ~exl_q;
        exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
        Req     = int_req | exc_req;
    end

    // A delay-slot victim restarts at the branch that precedes it.
    always_comb begin
        victim_pc = BDIn ? (VPC - 32'd4) : VPC;
    end

    // Next-state for SR/Cause/EPC; a taken request overrides mtc0 and eret.
    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        epc_d = epc_q;
        if (Req) begin
            exl_d = 1'b1;
            bd_d  = BDIn;
            exc_d = int_req ? 5'd0 : ExcCodeIn;
            epc_d = victim_pc[31:2];
        end else begin
            if (en && (CP0Add == AddrSr)) begin
                im_d  = CP0In[15:10];
                exl_d = CP0In[1];
                ie_d  = CP0In[0];
            end
            if (en && (CP0Add == AddrEpc)) begin
                epc_d = CP0In[31:2];
            end
            // eret takes precedence over a coincident SR write for EXL.
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    // State registers, including the two-flop HWInt synchronizer and Cause.IP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hw_m_q <= 6'd0;
            hw_s_q <= 6'd0;
            im_q   <= 6'd0;
            exl_q  <= 1'b0;
            ie_q   <= 1'b0;
            bd_q   <= 1'b0;
            ip_q   <= 6'd0;
            exc_q  <= 5'd0;
            epc_q  <= 30'd0;
        end else begin
            hw_m_q <= HWInt;
            hw_s_q <= hw_m_q;
            im_q   <= im_d;
            exl_q  <= exl_d;
            ie_q   <= ie_d;
            bd_q   <= bd_d;
            ip_q   <= hw_s_q;
            exc_q  <= exc_d;
            epc_q  <= epc_d;
        end
    end

    // mfc0 read mux; undefined bits and unmapped addresses read 0.
    always_comb begin
        CP0Out = 32'd0;
        unique case (CP0Add)
            AddrSr:    CP0Out = {16'd0, im_q, 8'd0, exl_q, ie_q};
            AddrCause: CP0Out = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'b00};
            AddrEpc:   CP0Out = {epc_q, 2'b00};
            AddrPrid:  CP0Out = PRID;
            default:   CP0Out = 32'd0;
        endcase
    end

    // eret redirect target; not bypassed from a same-cycle mtc0.
    always_comb begin
        EPCOut = {epc_q, 2'b00};
    end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Self-checking bench for cp0_exception_unit: directed steps followed by a
// randomized phase, all compared against a register-word reference model.
module tb_cp0_exception_unit;

    localparam logic [31:0] PRID = 32'h2022_0707;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  CP0Add;
    logic [31:0] CP0In;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    int passed = 0;
    int total  = 0;

    // Reference model state as architectural words.
    logic [31:0] m_sr, m_cause, m_epc;
    logic [5:0]  m_hist [2];  // [0] newest HWInt sample, [1] synchronized value

    cp0_exception_unit #(
        .PRID       (PRID),
        .HANDLER_PC (32'h0000_4180)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .CP0Add    (CP0Add),
        .CP0In     (CP0In),
        .CP0Out    (CP0Out),
        .VPC       (VPC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .EPCOut    (EPCOut),
        .Req       (Req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        assert (got === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    function automatic logic m_req();
        logic irq, exc;
        irq = ((m_hist[1] & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
        exc = (ExcCodeIn != 5'd0) && !m_sr[1];
        return irq || exc;
    endfunction

    function automatic logic m_irq();
        return ((m_hist[1] & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_sr    = 32'd0;
        m_cause = 32'd0;
        m_epc   = 32'd0;
        m_hist[0] = 6'd0;
        m_hist[1] = 6'd0;
    endtask

    // Apply what the architecture says happens at one rising edge.
    task automatic m_edge();
        logic        req, irq;
        logic [31:0] ip_word;
        req = m_req();
        irq = m_irq();
        ip_word = {16'd0, m_hist[1], 10'd0};
        m_hist[1] = m_hist[0];
        m_hist[0] = HWInt;
        m_cause = (m_cause & ~32'h0000_FC00) | ip_word;
        if (req) begin
            m_sr    = m_sr | 32'h2;
            m_cause = {BDIn, 15'd0, m_cause[15:10], 3'd0, (irq ? 5'd0 : ExcCodeIn), 2'b00};
            m_epc   = (BDIn ? VPC - 32'd4 : VPC) & ~32'h3;
        end else begin
            if (en && CP0Add == 5'd12) m_sr = CP0In & 32'h0000_FC03;
            if (en && CP0Add == 5'd14) m_epc = CP0In & ~32'h3;
            if (EXLClr) m_sr = m_sr & ~32'h2;
        end
    endtask

    // One clock: check combinational outputs, then advance DUT and model.
    task automatic cycle();
        #1;
        chk("req", {31'd0, Req}, {31'd0, m_req()});
        chk("cp0out", CP0Out, m_read(CP0Add));
        chk("epcout", EPCOut, m_epc);
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        en = 1'b0; EXLClr = 1'b0; ExcCodeIn = 5'd0; BDIn = 1'b0; CP0In = 32'd0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        en = 1'b1; CP0Add = a; CP0In = d;
        cycle();
        en = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
        CP0Add = a;
        #1;
        chk(tag, CP0Out, exp);
    endtask

    initial begin
        reset = 1'b0; HWInt = 6'd0; VPC = 32'd0; CP0Add = 5'd0;
        idle();
        m_reset();
        #12;
        chk("rst_req", {31'd0, Req}, 32'd0);
        chk("rst_epc", EPCOut, 32'd0);
        peek("rst_sr", 5'd12, 32'd0);
        peek("rst_cause", 5'd13, 32'd0);
        peek("rst_prid", 5'd15, PRID);
        @(negedge clk);
        reset = 1'b1;

        // Overflow in a normal slot.
        mtc0(5'd12, 32'h0000_FC01);
        ExcCodeIn = 5'd12; VPC = 32'h0000_3010; BDIn = 1'b0;
        #1 chk("ovf_req", {31'd0, Req}, 32'd1);
        cycle();
        idle();
        #1 chk("ovf_req_pulse", {31'd0, Req}, 32'd0);
        chk("ovf_epc", EPCOut, 32'h0000_3010);
        peek("ovf_exccode", 5'd13, 32'h0000_0030);
        peek("ovf_sr", 5'd12, 32'h0000_FC03);
        cycle();

        // Delay-slot overflow.
        EXLClr = 1'b1; cycle(); idle();
        ExcCodeIn = 5'd12; VPC = 32'h0000_3024; BDIn = 1'b1;
        cycle();
        idle();
        #1 chk("bd_epc", EPCOut, 32'h0000_3020);
        peek("bd_cause", 5'd13, 32'h8000_0030);
        EXLClr = 1'b1; cycle(); idle();

        // Interrupt and exception in the same cycle: interrupt wins.
        HWInt = 6'b000100;
        cycle(); cycle();
        ExcCodeIn = 5'd10; VPC = 32'h0000_3040;
        #1 chk("sim_req", {31'd0, Req}, 32'd1);
        cycle();
        idle(); HWInt = 6'd0;
        #1 chk("sim_epc", EPCOut, 32'h0000_3040);
        CP0Add = 5'd13; #1 chk("sim_exccode", {27'd0, CP0Out[6:2]}, 32'd0);
        cycle(); cycle(); cycle();
        EXLClr = 1'b1; cycle(); idle();

        // Masked interrupt, then unmask via mtc0.
        mtc0(5'd12, 32'h0000_0401);
        HWInt = 6'b000100;
        cycle(); cycle(); cycle();
        #1 chk("mask_req", {31'd0, Req}, 32'd0);
        CP0Add = 5'd13; #1 chk("mask_ip", {26'd0, CP0Out[15:10]}, 32'd4);
        mtc0(5'd12, 32'h0000_1401);
        #1 chk("unmask_req", {31'd0, Req}, 32'd1);
        cycle();
        HWInt = 6'd0;
        cycle(); cycle(); cycle();

        // eret colliding with mtc0 SR while EXL=1.
        en = 1'b1; EXLClr = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0003;
        cycle(); idle();
        peek("eret_mtc0_sr", 5'd12, 32'h0000_0001);
        // Same collision with an exception pending: exception wins.
        en = 1'b1; EXLClr = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_FC00;
        ExcCodeIn = 5'd4; VPC = 32'h0000_3100;
        cycle(); idle();
        peek("exc_wins_sr", 5'd12, 32'h0000_0003);
        chk("exc_wins_epc", EPCOut, 32'h0000_3100);

        // Read-only registers and EPC alignment.
        mtc0(5'd13, 32'hFFFF_FFFF);
        mtc0(5'd15, 32'h0000_0000);
        peek("ro_cause", 5'd13, 32'h0000_0010);
        peek("ro_prid", 5'd15, PRID);
        mtc0(5'd14, 32'h0000_3007);
        peek("epc_align", 5'd14, 32'h0000_3004);
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 3) == 0);
            EXLClr    = ($urandom_range(0, 5) == 0);
            CP0Add    = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(12, 15))
                                                    : 5'($urandom);
            CP0In     = $urandom;
            VPC       = $urandom;
            BDIn      = 1'($urandom);
            ExcCodeIn = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            if ($urandom_range(0, 7) == 0) HWInt = 6'($urandom);
            cycle();
        end

        // Asynchronous reset in the middle of a handler.
        idle(); HWInt = 6'd0;
        cycle(); cycle(); cycle();
        en = 1'b1; EXLClr = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0001;
        cycle(); idle();
        ExcCodeIn = 5'd8; VPC = 32'h0000_5000;
        cycle(); idle();
        chk("pre_rst_epc", EPCOut, 32'h0000_5000);
        CP0Add = 5'd12;
        #2 reset = 1'b0;
        m_reset();
        #1;
        chk("async_rst_epc", EPCOut, 32'd0);
        chk("async_rst_sr", CP0Out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cycle(); cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
